// File: rtl/imem_loader_if.sv
// Host beat stream and IMem write port bundled for imem_loader.
// The slave modport is the loader side; the master modport is the host/boot side.
interface imem_loader_if #(
    parameter int ADDR_W = 6
);
    logic              host_valid;
    logic [31:0]       host_data;
    logic              host_last;
    logic              host_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output host_valid, host_data, host_last,
        input  host_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  host_valid, host_data, host_last,
        output host_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: streams a host image into the fetch-stage IMem while holding the core in reset.
// Define IMEM_CKSUM_EN to treat the final beat as a 32-bit wrap-around checksum of the image.
module imem_loader #(
    parameter int IMEM_SIZE   = 64,
    parameter int ADDR_W      = 6,
    parameter int HOLD_CYCLES = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            start,
    imem_loader_if.slave    bus,
    output logic            core_hold,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [ADDR_W:0] word_count
);
    localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [ADDR_W:0]  MAX_WORDS = (ADDR_W + 1)'(IMEM_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_RELEASE,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [31:0]       imem_wdata_q;
    logic [HC_W-1:0]   hold_cnt;

    logic accept;
    logic data_beat;
    logic full;
    logic session_start;
    logic cksum_mismatch;
    logic wr_d;
    logic overflow;
    logic cksum_bad;

    assign accept        = bus.host_valid && bus.host_ready;
    assign full          = (word_count == MAX_WORDS);
    assign session_start = start && ((state_q == S_IDLE) || (state_q == S_ERROR));

`ifdef IMEM_CKSUM_EN
    logic [31:0] cksum_q;

    // The final beat carries the checksum and is never written.
    assign data_beat      = !bus.host_last;
    assign cksum_mismatch = (cksum_q != bus.host_data);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cksum_q <= '0;
        end else if (session_start) begin
            cksum_q <= '0;
        end else if (wr_d) begin
            cksum_q <= cksum_q + bus.host_data;
        end
    end
`else
    assign data_beat      = 1'b1;
    assign cksum_mismatch = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path infers a latch.
        state_d   = state_q;
        wr_d      = 1'b0;
        overflow  = 1'b0;
        cksum_bad = 1'b0;
        unique case (state_q)
            S_IDLE, S_ERROR: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (accept) begin
                    if (data_beat && full) begin
                        overflow = 1'b1;
                        state_d  = bus.host_last ? S_ERROR : S_DRAIN;
                    end else begin
                        wr_d = data_beat;
                        if (bus.host_last) begin
                            if (cksum_mismatch) begin
                                cksum_bad = 1'b1;
                                state_d   = S_ERROR;
                            end else begin
                                state_d = S_RELEASE;
                            end
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (accept && bus.host_last) state_d = S_ERROR;
            end
            S_RELEASE: begin
                // Hold cycles count only once the final write has left the port.
                if (!imem_we_q && (hold_cnt == HOLD_LAST)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            word_count   <= '0;
            err          <= 1'b0;
            done         <= 1'b0;
            hold_cnt     <= '0;
        end else begin
            imem_we_q <= wr_d;
            done      <= (state_q == S_RELEASE) && (state_d == S_IDLE);

            if (state_q != S_RELEASE) begin
                hold_cnt <= '0;
            end else if (!imem_we_q) begin
                hold_cnt <= hold_cnt + 1'b1;
            end

            if (session_start) begin
                word_count <= '0;
                err        <= 1'b0;
            end else if (wr_d) begin
                imem_addr_q  <= word_count[ADDR_W-1:0];
                imem_wdata_q <= bus.host_data;
                word_count   <= word_count + 1'b1;
            end

            if (overflow || cksum_bad) err <= 1'b1;
        end
    end

    assign bus.host_ready = (state_q == S_LOAD) || (state_q == S_DRAIN);
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign core_hold      = (state_q != S_IDLE);
    assign busy           = (state_q == S_LOAD) || (state_q == S_DRAIN) || (state_q == S_RELEASE);
endmodule
